alu_exec_mdu: RTL

- Parametrised successor to the combinational ALU control decode.
- Decodes ALUOp plus instruction fields, including RV32M. Executes the selected operation on two XLEN operands.
- Returns the result over a valid/ready handshake.
- Base ops take 1 cycle. MUL/DIV families use an iterative 1-bit-per-cycle datapath. Sits in EX, between ID/EX register and EX/MEM register; the pipeline stalls on in_ready=0.

---
 rtl/alu_exec_mdu.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_mdu.sv
// EX-stage ALU with RV32M support: single-cycle base ops, iterative shift-add multiply
// and restoring divide, result returned over a valid/ready handshake.
module alu_exec_mdu #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      op_sel
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_PASS = 5'd15;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);

  state_t            state;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb_mag;
  logic [SHW-1:0]    cnt;
  logic [2:0]        mdu_f3;
  logic              neg_res;
  logic              neg_rem;

  logic [2:0]      funct3;
  logic            is_mdu;
  logic [4:0]      dec_sel;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;
  logic            unused_inst;

  assign funct3      = inst[14:12];
  assign is_mdu      = (alu_op == 2'b10) && inst[5] && (inst[31:25] == 7'b0000001);
  assign shamt       = op_b[SHW-1:0];
  assign in_ready    = (state == S_IDLE);
  assign unused_inst = ^{inst[24:15], inst[11:6], inst[4:0]};

  always_comb begin
    dec_sel = OP_ADD;
    case (alu_op)
      2'b00: dec_sel = OP_ADD;
      2'b01: dec_sel = OP_SUB;
      2'b11: dec_sel = OP_PASS;
      default: begin
        if (is_mdu) begin
          dec_sel = {2'b10, funct3};
        end else begin
          case (funct3)
            3'b000:  dec_sel = (inst[5] && inst[30]) ? OP_SUB : OP_ADD;
            3'b001:  dec_sel = OP_SLL;
            3'b010:  dec_sel = OP_SLT;
            3'b011:  dec_sel = OP_SLTU;
            3'b100:  dec_sel = OP_XOR;
            3'b101:  dec_sel = inst[30] ? OP_SRA : OP_SRL;
            3'b110:  dec_sel = OP_OR;
            default: dec_sel = OP_AND;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    base_res = '0;
    case (dec_sel[3:0])
      4'd0:    base_res = op_a + op_b;
      4'd1:    base_res = op_a - op_b;
      4'd2:    base_res = op_a << shamt;
      4'd3:    base_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd4:    base_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'd5:    base_res = op_a ^ op_b;
      4'd6:    base_res = op_a >> shamt;
      4'd7:    base_res = XLEN'($signed(op_a) >>> shamt);
      4'd8:    base_res = op_a | op_b;
      4'd9:    base_res = op_a & op_b;
      4'd15:   base_res = op_b;
      default: base_res = '0;
    endcase
  end

  // Divide-by-zero and signed overflow bypass the iterative divider entirely.
  logic            is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0] spec_res;
  assign is_div   = is_mdu && funct3[2];
  assign div_zero = (op_b == '0);
  assign div_ovf  = !funct3[0] && (op_a == MIN_NEG) && (&op_b);
  assign special  = is_div && (div_zero || div_ovf);
  assign spec_res = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);

  logic            sgn_a, sgn_b, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  assign sgn_a = funct3[2] ? !funct3[0] : (funct3 != 3'b011);
  assign sgn_b = funct3[2] ? !funct3[0] : !funct3[1];
  assign a_neg = sgn_a && op_a[XLEN-1];
  assign b_neg = sgn_b && op_b[XLEN-1];
  assign mag_a = a_neg ? -op_a : op_a;
  assign mag_b = b_neg ? -op_b : op_b;

  // acc holds {hi, lo}: product/multiplier for MUL, remainder/quotient for DIV.
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next, mul_prod;
  logic [XLEN-1:0]   mul_res, div_res, div_q, div_r;
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_mag} : {(XLEN+1){1'b0}});
  assign mul_next  = {mul_sum, acc[XLEN-1:1]};
  assign div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opb_mag};
  assign div_next  = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign mul_prod  = neg_res ? -mul_next : mul_next;
  assign mul_res   = (mdu_f3[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  assign div_q     = div_next[XLEN-1:0];
  assign div_r     = div_next[2*XLEN-1:XLEN];
  assign div_res   = mdu_f3[1] ? (neg_rem ? -div_r : div_r) : (neg_res ? -div_q : div_q);

  // The final iteration writes the sign-corrected result directly, giving XLEN+1 latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      op_sel    <= '0;
      acc       <= '0;
      opb_mag   <= '0;
      cnt       <= '0;
      mdu_f3    <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (is_mdu && !special) begin
              acc     <= {{XLEN{1'b0}}, mag_a};
              opb_mag <= mag_b;
              cnt     <= '0;
              mdu_f3  <= funct3;
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              state   <= funct3[2] ? S_DIV : S_MUL;
            end else begin
              result    <= is_mdu ? spec_res : base_res;
              op_sel    <= dec_sel;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            result    <= mul_res;
            op_sel    <= {2'b10, mdu_f3};
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            result    <= div_res;
            op_sel    <= {2'b10, mdu_f3};
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
